// File: rtl/seg_msg_sequencer.sv
// Steps a seven-segment display through a fixed message table, driven by a
// debounced push-button and/or a rate-selectable auto-advance timer.
module seg_msg_sequencer #(
    parameter int                   MSG_LEN   = 14,
    parameter logic [8*MSG_LEN-1:0] MSG       = 112'h0E3E157E5F0E3E5F0E7E154F5B80,
    parameter int                   DB_CYCLES = 16,
    parameter int                   DIV_BASE  = 1000000,
    localparam int                  IDX_W     = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step_in,
    input  logic             mode_auto,
    input  logic             dir,
    input  logic             pause,
    input  logic [1:0]       rate,
    output logic [7:0]       seg_out,
    output logic [IDX_W-1:0] index,
    output logic             wrap
);

    localparam int DB_W  = $clog2(DB_CYCLES);
    localparam int PRE_W = $clog2(DIV_BASE) + 4;

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_LEN - 1);

    logic [7:0] msg_rom [MSG_LEN];

    for (genvar gi = 0; gi < MSG_LEN; gi++) begin : g_rom
        assign msg_rom[gi] = MSG[8*gi +: 8];
    end

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             db_q, db_d;
    logic             db_prev_q, db_prev_d;
    logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic [7:0]       seg_q, seg_d;
    logic             wrap_q, wrap_d;

    logic             step_ev;
    logic             tick;
    logic             advance;
    logic             at_end;
    logic [PRE_W-1:0] period_m1;

    // Debounce: db only follows q2 after DB_CYCLES consecutive disagreeing samples.
    always_comb begin
        sync1_d   = step_in;
        sync2_d   = sync1_q;
        db_prev_d = db_q;
        db_d      = db_q;
        db_cnt_d  = db_cnt_q;
        if (sync2_q == db_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            db_d     = sync2_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
        end
    end

    assign step_ev = db_q & ~db_prev_q;

    // Using >= rather than == makes a rate decrease mid-period tick at once.
    assign period_m1 = (PRE_W'(DIV_BASE) << rate) - PRE_W'(1);
    assign tick      = mode_auto & ~pause & (pre_cnt_q >= period_m1);

    always_comb begin
        pre_cnt_d = pre_cnt_q;
        if (!mode_auto || step_ev) begin
            pre_cnt_d = '0;
        end else if (!pause) begin
            pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
        end
    end

    assign advance = step_ev | tick;
    assign at_end  = dir ? (index_q == '0) : (index_q == IDX_LAST);

    always_comb begin
        index_d = index_q;
        wrap_d  = 1'b0;
        if (advance) begin
            wrap_d = at_end;
            if (dir) begin
                index_d = at_end ? IDX_LAST : index_q - IDX_W'(1);
            end else begin
                index_d = at_end ? '0 : index_q + IDX_W'(1);
            end
        end
        seg_d = msg_rom[index_d];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            db_cnt_q  <= '0;
            pre_cnt_q <= '0;
            index_q   <= '0;
            seg_q     <= MSG[7:0];
            wrap_q    <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            db_q      <= db_d;
            db_prev_q <= db_prev_d;
            db_cnt_q  <= db_cnt_d;
            pre_cnt_q <= pre_cnt_d;
            index_q   <= index_d;
            seg_q     <= seg_d;
            wrap_q    <= wrap_d;
        end
    end

    assign seg_out = seg_q;
    assign index   = index_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_seg_msg_sequencer.sv
// Bench for seg_msg_sequencer: behavioural model compared every cycle, plus
// directed scenarios with hand-computed timing and pattern expectations.
module tb_seg_msg_sequencer;

    localparam int N    = 14;
    localparam int DB   = 4;
    localparam int DIVB = 8;
    localparam logic [8*N-1:0] MSGP = 112'h0E3E157E5F0E3E5F0E7E154F5B80;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       step_in = 1'b0;
    logic       mode_auto = 1'b0;
    logic       dir = 1'b0;
    logic       pause = 1'b0;
    logic [1:0] rate = 2'd0;
    logic [7:0] seg_out;
    logic [3:0] index;
    logic       wrap;

    always #5 clk = ~clk;

    seg_msg_sequencer #(
        .MSG_LEN  (N),
        .MSG      (MSGP),
        .DB_CYCLES(DB),
        .DIV_BASE (DIVB)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .step_in  (step_in),
        .mode_auto(mode_auto),
        .dir      (dir),
        .pause    (pause),
        .rate     (rate),
        .seg_out  (seg_out),
        .index    (index),
        .wrap     (wrap)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Behavioural model state
    bit model_valid = 0;
    int m_q1, m_q2, m_db, m_db_prev, m_run, m_elapsed, m_idx;
    bit m_wrap;
    int adv_times[$];
    int wrap_cnt     = 0;
    int dut_wrap_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: advance at each rising edge from the inputs present there,
    // then compare DUT outputs on the following falling edge.
    initial begin : model_proc
        bit ev, tk, adv;
        int period;
        forever begin
            @(posedge clk);
            cyc++;
            if (!rst_n) begin
                m_q1 = 0; m_q2 = 0; m_db = 0; m_db_prev = 0; m_run = 0;
                m_elapsed = 0; m_idx = 0; m_wrap = 0;
                model_valid = 1;
            end else begin
                period = DIVB << rate;
                ev  = (m_db == 1) && (m_db_prev == 0);
                tk  = mode_auto && !pause && (m_elapsed >= period - 1);
                adv = ev || tk;
                if (!mode_auto || ev) m_elapsed = 0;
                else if (!pause) m_elapsed = tk ? 0 : m_elapsed + 1;
                m_db_prev = m_db;
                if (m_q2 != m_db) begin
                    m_run++;
                    if (m_run == DB) begin
                        m_db  = m_q2;
                        m_run = 0;
                    end
                end else begin
                    m_run = 0;
                end
                m_q2 = m_q1;
                m_q1 = int'(step_in);
                m_wrap = 0;
                if (adv) begin
                    if (!dir) begin
                        m_wrap = (m_idx == N - 1);
                        m_idx  = (m_idx + 1) % N;
                    end else begin
                        m_wrap = (m_idx == 0);
                        m_idx  = (m_idx + N - 1) % N;
                    end
                    adv_times.push_back(cyc);
                    if (m_wrap) wrap_cnt++;
                end
            end
            @(negedge clk);
            if (model_valid) begin
                check("index", int'(index), m_idx);
                check("seg_out", int'(seg_out), int'(8'(MSGP >> (8 * m_idx))));
                check("wrap", int'(wrap), int'(m_wrap));
                if (wrap) dut_wrap_cnt++;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cycles(2);
        rst_n = 1'b1;
        cycles(1);
    endtask

    task automatic press();
        step_in = 1'b1;
        cycles(DB + 4);
        step_in = 1'b0;
        cycles(DB + 4);
    endtask

    task automatic wait_adv(input int limit);
        int n0;
        bit seen;
        n0 = adv_times.size();
        seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (adv_times.size() != n0) seen = 1;
        end
        check("adv_timeout", int'(seen), 1);
    endtask

    initial begin : stim
        int n0, w0, dw0, t0, t1;
        bit found;

        // Reset state
        cycles(3);
        check("rst_index", int'(index), 0);
        check("rst_seg", int'(seg_out), 8'h80);
        check("rst_wrap", int'(wrap), 0);
        rst_n = 1'b1;
        cycles(3);

        // Clean press: index changes exactly DB+2 edges after first high sample
        n0 = adv_times.size();
        step_in = 1'b1;
        cycles(DB + 2);
        check("press_early_index", int'(index), 0);
        cycles(1);
        check("press_index", int'(index), 1);
        check("press_seg", int'(seg_out), 8'h5B);
        cycles(20 - (DB + 3));
        step_in = 1'b0;
        cycles(20);
        check("press_single_adv", adv_times.size() - n0, 1);
        check("press_hold_index", int'(index), 1);
        $display("scenario clean_press: index=%0d seg=%02h", index, seg_out);

        // Short pulses are rejected by the debouncer
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step_in = 1'b1;
            cycles(3);
            step_in = 1'b0;
            cycles(3);
        end
        cycles(10);
        check("glitch_index", int'(index), 0);
        check("glitch_seg", int'(seg_out), 8'h80);
        $display("scenario glitches: index=%0d seg=%02h", index, seg_out);

        // 14 forward presses wrap once; one reverse press wraps back
        w0 = wrap_cnt; dw0 = dut_wrap_cnt;
        for (int i = 0; i < N; i++) press();
        check("fwd_final_index", int'(index), 0);
        check("fwd_model_wraps", wrap_cnt - w0, 1);
        check("fwd_dut_wraps", dut_wrap_cnt - dw0, 1);
        dir = 1'b1;
        w0 = wrap_cnt; dw0 = dut_wrap_cnt;
        press();
        check("rev_index", int'(index), 13);
        check("rev_seg", int'(seg_out), 8'h0E);
        check("rev_dut_wraps", dut_wrap_cnt - dw0, 1);
        dir = 1'b0;
        $display("scenario manual_wrap: index=%0d seg=%02h", index, seg_out);

        // Auto advance periods and pause
        do_reset();
        mode_auto = 1'b1;
        rate = 2'd0;
        cycles(40);
        check("auto_r0_gap", adv_times[$] - adv_times[$-1], 8);
        rate = 2'd2;
        cycles(100);
        check("auto_r2_gap", adv_times[$] - adv_times[$-1], 32);
        t0 = adv_times[$];
        pause = 1'b1;
        cycles(20);
        pause = 1'b0;
        wait_adv(100);
        check("pause_gap", adv_times[$] - t0, 52);
        $display("scenario auto: index=%0d seg=%02h", index, seg_out);

        // Step event landing on the tick edge
        rate = 2'd0;
        cycles(20);
        wait_adv(50);
        t0 = adv_times[$];
        n0 = adv_times.size();
        cycles(1);
        step_in = 1'b1;
        cycles(DB + 4);
        step_in = 1'b0;
        cycles(12);
        if (adv_times.size() >= n0 + 2) begin
            check("coinc_first_gap", adv_times[n0] - t0, 8);
            check("coinc_next_gap", adv_times[n0+1] - t0, 16);
        end else begin
            check("coinc_adv_count", adv_times.size() - n0, 2);
        end
        $display("scenario coincident: index=%0d seg=%02h", index, seg_out);

        // Reset at index 7 in auto mode while a press is being debounced
        rate = 2'd2;
        found = 0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clk);
            if (index == 4'd7) found = 1;
        end
        check("reach_index7", int'(found), 1);
        step_in = 1'b1;
        cycles(3);
        check("pre_rst_index", int'(index), 7);
        rst_n = 1'b0;
        cycles(1);
        check("midrst_index", int'(index), 0);
        check("midrst_seg", int'(seg_out), 8'h80);
        check("midrst_wrap", int'(wrap), 0);
        mode_auto = 1'b0;
        step_in = 1'b0;
        cycles(1);
        rst_n = 1'b1;
        n0 = adv_times.size();
        cycles(20);
        check("midrst_no_pending", adv_times.size() - n0, 0);
        check("midrst_hold_index", int'(index), 0);
        $display("scenario mid_reset: index=%0d seg=%02h", index, seg_out);

        // Button already held across reset release counts as a fresh press
        step_in = 1'b1;
        do_reset();
        cycles(20);
        check("held_press_index", int'(index), 1);
        step_in = 1'b0;
        cycles(20);
        check("held_release_index", int'(index), 1);
        $display("scenario held_through_reset: index=%0d seg=%02h", index, seg_out);

        // Randomized mix of all inputs
        for (int i = 0; i < 700; i++) begin
            step_in = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) mode_auto = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) dir = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) pause = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) rate = 2'($urandom_range(0, 3));
            rst_n = ($urandom_range(0, 149) != 0);
            cycles($urandom_range(1, 12));
        end
        rst_n = 1'b1;
        cycles(5);
        $display("scenario random: index=%0d seg=%02h", index, seg_out);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seg_msg_sequencer.md
SEG_MSG_SEQUENCER -- requirements
Module: seg_msg_sequencer

Interface
REQ-001 SHALL: parameter MSG_LEN, default 14, number of message entries (>=2).
REQ-002 SHALL: parameter MSG, default 112'h0E3E157E5F0E3E5F0E7E154F5B80, packed MSG_LEN x 8-bit segment patterns {dp,a,b,c,d,e,f,g}, entry 0 in bits [7:0].
REQ-003 SHALL: parameter DB_CYCLES, default 16, debounce stability count (>=2).
REQ-004 SHALL: parameter DIV_BASE, default 1000000, auto-advance base period in clocks (>=2).
REQ-005 SHALL: localparam IDX_W = max(1, clog2(MSG_LEN)).
REQ-006 SHALL: clk  in  1  single clock; all state changes on rising edge.
REQ-007 SHALL: rst_n  in  1  synchronous, active-low reset.
REQ-008 SHALL: step_in  in  1  raw asynchronous push-button, active high.
REQ-009 SHALL: mode_auto  in  1  0 = manual stepping, 1 = timed auto-advance.
REQ-010 SHALL: dir  in  1  0 = forward (index+1), 1 = reverse (index-1).
REQ-011 SHALL: pause  in  1  1 = suppress auto ticks (manual steps still honoured).
REQ-012 SHALL: rate  in  2  auto period select: period = DIV_BASE << rate clocks.
REQ-013 SHALL: seg_out  out  8  registered segment pattern, always equal to MSG entry[index].
REQ-014 SHALL: index  out  IDX_W  registered current message position, 0..MSG_LEN-1.
REQ-015 SHALL: wrap  out  1  registered one-cycle pulse on each wrap-around advance.

Function
REQ-016 SHALL: step_in pass through a 2-flop synchroniser (q1, q2) before any other use.
REQ-017 SHALL: debounce — counter clears when q2 equals debounced state db; otherwise increments; on the edge where counter==DB_CYCLES-1, db<=q2 and counter<=0.
REQ-018 SHALL: step event = db rising edge (db=1, db_prev=0), one cycle wide; falling edges produce no event.
REQ-019 SHALL: step_in high sampled first at edge k (held stable) -> index updates at edge k+DB_CYCLES+2.
REQ-020 SHALL: any step_in pulse/glitch shorter than DB_CYCLES clocks at q2 produce no advance.
REQ-021 SHALL: prescaler count 0..(DIV_BASE<<rate)-1 while mode_auto=1 and pause=0; auto tick issued at terminal count, counter returns to 0.
REQ-022 SHALL: prescaler hold value while pause=1; clear to 0 whenever mode_auto=0.
REQ-023 SHALL: rate change mid-period — if count >= new terminal count, tick on next edge and restart from 0.
REQ-024 SHALL: advance = step event (any mode) OR auto tick (mode_auto=1, pause=0); coincident step+tick produce exactly one advance.
REQ-025 SHALL: a step event in auto mode clear the prescaler, restarting the full period.
REQ-026 SHALL: forward advance — index MSG_LEN-1 -> 0 with wrap=1; otherwise index+1, wrap=0.
REQ-027 SHALL: reverse advance — index 0 -> MSG_LEN-1 with wrap=1; otherwise index-1, wrap=0.
REQ-028 SHALL: index, seg_out and wrap update on the same edge (seg_out loaded from next index); no advance -> wrap=0, index/seg_out hold.
REQ-029 SHALL: dir, mode_auto, pause, rate sampled at each edge; changes take effect on the next advance with no lost or extra step.
REQ-030 SHALL: index never hold a value >= MSG_LEN, including non-power-of-two MSG_LEN.

Reset
REQ-031 SHALL: rst_n=0 at an edge force index=0, seg_out=MSG entry 0, wrap=0, q1=q2=db=db_prev=0, debounce counter=0, prescaler=0.
REQ-032 SHALL: reset take priority over every concurrent advance, step or tick, including mid-debounce and mid-period.
REQ-033 SHALL: after release, step_in already high be treated as a fresh press (one advance after debounce).

Verification (bench parameters MSG_LEN=14, DB_CYCLES=4, DIV_BASE=8, default MSG)
REQ-034 SHALL: reset, then step_in high from edge 10, held 20 clocks -> index 0->1 at edge 16, seg_out 8'h80->8'h5B, exactly one advance.
REQ-035 SHALL: step_in 3-clock pulses separated by 3 low clocks, x10 -> index stays 0, seg_out stays 8'h80.
REQ-036 SHALL: manual, dir=0, 14 clean presses -> index 1..13 then 0, wrap=1 for exactly one cycle on 13->0; dir=1 from 0 -> index 13, seg_out 8'h0E, wrap=1.
REQ-037 SHALL: mode_auto=1, rate=0 -> advance every 8 clocks; rate=2 -> every 32; pause=1 for 20 clocks -> no advance, then resume with remaining count preserved.
REQ-038 SHALL: auto mode, step event landing on the tick cycle -> single advance, next tick a full period later.
REQ-039 SHALL: rst_n low mid-debounce and at index 7 in auto mode -> next edge index=0, seg_out=8'h80, wrap=0, no pending step after release.
